program_run_checker: RTL and testbench
======================================

# program_run_checker

Synthesizable run-and-check harness that wraps the single-cycle MIPS processor. It holds the core in reset, releases it for a programmable cycle budget, then scans the general-purpose register file through a read port and compares each register against an expected-value source. It reports pass/fail with the first mismatching register. It generalises the fixed-delay, fixed-32-register bench check with parameterised widths and register count, a runtime budget, and an optional early-halt mode.

## Interface
- `DATA_W`, 32, register/PC width
- `NUM_REGS`, 32, register count; index 0 is never checked
- `IDX_W`, `$clog2(NUM_REGS)`, register index width
- `CYC_W`, 16, cycle budget/counter width
- `HALT_MODE`, 0; 0 = run exactly the budget; 1 = also stop early on halt
- `HALT_STABLE`, 4, consecutive cycles with unchanged `pc` that count as a halt (HALT_MODE=1 only)
- `clk`  in  1  clock; everything is rising-edge
- `reset`  in  1  synchronous, active-low
- `start`  in  1  one-cycle request; sampled in IDLE or DONE only
- `cycle_budget`  in  CYC_W  processor cycles to run; sampled with `start`
- `cpu_reset`  out  1  active-high reset to the processor
- `pc`  in  DATA_W  processor PC, used for halt detection
- `reg_idx`  out  IDX_W  register-file / expected-ROM read address
- `reg_data`  in  DATA_W  actual value, valid 1 cycle after `reg_idx`
- `exp_data`  in  DATA_W  expected value, valid 1 cycle after `reg_idx`
- `busy`  out  1  high from the cycle after accepted `start` until DONE
- `done`  out  1  level, high in DONE
- `pass`  out  1  valid while `done`
- `halted`  out  1  run ended by halt detection, not by budget
- `fail_idx`  out  IDX_W  first mismatching index (0 if pass)
- `fail_got`, `fail_exp`  out  DATA_W  actual and expected values at `fail_idx`
- `cycles_run`  out  CYC_W  processor cycles actually executed

## Operation
- States: IDLE → CPURST → RUN → SCAN → DONE. `start` in DONE re-enters CPURST.
- Reset values (`reset`=0): state IDLE, `cpu_reset`=1, `reg_idx`=0, `busy`=`done`=`pass`=`halted`=0, `fail_*`=0, `cycles_run`=0.
- IDLE: `cpu_reset`=1. On `start`, latch `cycle_budget`, clear results, go to CPURST.
- CPURST: one cycle with `cpu_reset`=1. Next state is RUN, or SCAN directly if the latched budget is 0.
- RUN: `cpu_reset`=0 and `cycles_run` increments each cycle. Leave when `cycles_run+1`==budget.
  - HALT_MODE=1: a stability counter increments when `pc` equals its previous-cycle value and clears otherwise. Reaching HALT_STABLE sets `halted` and goes to SCAN.
  - If the budget end and halt occur in the same cycle, `halted`=1.
- SCAN: `cpu_reset`=1 (core frozen). `reg_idx` steps 1..NUM_REGS-1, one per cycle. The compare for index k happens the cycle after k is issued.
  - First mismatch latches `fail_idx`/`fail_got`/`fail_exp`, stops issuing, and goes to DONE with `pass`=0.
  - Compare of NUM_REGS-1 matching goes to DONE with `pass`=1.
  - Comparison is full-width equality; there are no don't-care bits.
- DONE: outputs held until `start` or reset. `start` while `busy` is ignored.
- Mid-operation reset: next cycle is IDLE with reset values. No partial result survives.

## Timing
- `start` at cycle 0: CPURST at cycle 1, RUN cycles 2..B+1, SCAN begins at B+2.
- A full passing scan lasts NUM_REGS-1 issue cycles plus 1 compare cycle. `done` rises at cycle B+2+NUM_REGS.
- A mismatch at index k raises `done` at cycle B+2+k+1 (the pipeline adds one cycle after the last issue).
- `cycles_run` is saturating: it never wraps, and budget ≤ 2^CYC_W-1.

## Structure
- A shared package `checker_pkg` holds the state enum (IDLE, CPURST, RUN, SCAN, DONE) and the default widths.
- One sub-module, `halt_detector` (pc register, stability counter, `halt` output), is instantiated only when HALT_MODE=1.
- The expected ROM stays outside the block; the bench loads it from the `.expected` file.

## Test plan
- Fibonacci program, budget 29, expected file correct → `done` at cycle 63 (NUM_REGS=32), `pass`=1, `cycles_run`=29, `halted`=0.
- Expected value for r7 corrupted to 0xdeadbeef → `pass`=0, `fail_idx`=7, `fail_exp`=0xdeadbeef, `done` at cycle B+10.
- r1 and r31 both wrong → `fail_idx`=1; r31 is never reported.
- `cycle_budget`=0 → RUN skipped, `cycles_run`=0, scan starts at cycle 2, `cpu_reset` never drops.
- HALT_MODE=1 with a program ending in a self-branch, budget 400 → `halted`=1 and `cycles_run` < 400. A second `start` pulse mid-RUN has no effect.
- `reset` driven low during SCAN → next cycle IDLE with every output at its reset value. A new `start` then completes normally.

Source files
------------

// File: rtl/checker_pkg.sv
// rtl/checker_pkg.sv - shared state encoding and default widths for the program run checker
package checker_pkg;

    localparam int DEF_DATA_W      = 32;
    localparam int DEF_NUM_REGS    = 32;
    localparam int DEF_CYC_W       = 16;
    localparam int DEF_HALT_STABLE = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CPURST,
        ST_RUN,
        ST_SCAN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/program_run_checker_halt_detector.sv
// rtl/program_run_checker_halt_detector.sv - flags a core halt once pc has stopped moving for HALT_STABLE cycles
module halt_detector
    import checker_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int HALT_STABLE = DEF_HALT_STABLE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [DATA_W-1:0] pc,
    output logic              halt
);

    localparam int                CNT_W     = $clog2(HALT_STABLE + 1);
    localparam logic [CNT_W-1:0] STABLE_M1 = CNT_W'(HALT_STABLE - 1);

    logic [DATA_W-1:0] pc_q;
    logic [CNT_W-1:0]  cnt;
    logic              same;

    assign same = (pc == pc_q);

    // Track last-cycle pc and count consecutive unchanged cycles while enabled
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q <= '0;
            cnt  <= '0;
        end else begin
            pc_q <= pc;
            if (!en || !same) begin
                cnt <= '0;
            end else if (cnt != STABLE_M1) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // The current unchanged cycle is the HALT_STABLE-th in a row
    assign halt = en && same && (cnt >= STABLE_M1);

endmodule

// File: rtl/program_run_checker.sv
// rtl/program_run_checker.sv - runs the core for a cycle budget then scans and checks its register file
module program_run_checker
    import checker_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int NUM_REGS    = DEF_NUM_REGS,
    parameter int IDX_W       = $clog2(NUM_REGS),
    parameter int CYC_W       = DEF_CYC_W,
    parameter int HALT_MODE   = 0,
    parameter int HALT_STABLE = DEF_HALT_STABLE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CYC_W-1:0]  cycle_budget,
    output logic              cpu_reset,
    input  logic [DATA_W-1:0] pc,
    output logic [IDX_W-1:0]  reg_idx,
    input  logic [DATA_W-1:0] reg_data,
    input  logic [DATA_W-1:0] exp_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              halted,
    output logic [IDX_W-1:0]  fail_idx,
    output logic [DATA_W-1:0] fail_got,
    output logic [DATA_W-1:0] fail_exp,
    output logic [CYC_W-1:0]  cycles_run
);

    localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REGS - 1);

    state_t            state_q, state_d;
    logic [CYC_W-1:0]  budget_q;
    logic              cmp_valid;
    logic [IDX_W-1:0]  cmp_idx;
    logic              halt_hit;
    logic              run_last;
    logic              run_exit;
    logic              mismatch;
    logic              scan_end;

    assign run_last = ((cycles_run + CYC_W'(1)) == budget_q);
    assign run_exit = run_last || halt_hit;
    assign mismatch = cmp_valid && (reg_data != exp_data);
    assign scan_end = cmp_valid && (mismatch || (cmp_idx == LAST_IDX));

    generate
        if (HALT_MODE != 0) begin : g_halt
            halt_detector #(
                .DATA_W      (DATA_W),
                .HALT_STABLE (HALT_STABLE)
            ) u_halt (
                .clk   (clk),
                .reset (reset),
                .en    (state_q == ST_RUN),
                .pc    (pc),
                .halt  (halt_hit)
            );
        end else begin : g_no_halt
            logic unused_pc;
            assign unused_pc = ^pc;
            assign halt_hit  = 1'b0;
        end
    endgenerate

    // Next-state and state-decoded outputs; the core runs only in RUN
    always_comb begin
        state_d   = state_q;
        cpu_reset = 1'b1;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_CPURST;
            end
            ST_CPURST: begin
                busy    = 1'b1;
                state_d = (budget_q == '0) ? ST_SCAN : ST_RUN;
            end
            ST_RUN: begin
                busy      = 1'b1;
                cpu_reset = 1'b0;
                if (run_exit) state_d = ST_SCAN;
            end
            ST_SCAN: begin
                busy = 1'b1;
                if (scan_end) state_d = ST_DONE;
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) state_d = ST_CPURST;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Budget latch, run counter, scan address pipeline and result capture
    always_ff @(posedge clk) begin
        if (!reset) begin
            budget_q   <= '0;
            cycles_run <= '0;
            reg_idx    <= '0;
            cmp_valid  <= 1'b0;
            cmp_idx    <= '0;
            pass       <= 1'b0;
            halted     <= 1'b0;
            fail_idx   <= '0;
            fail_got   <= '0;
            fail_exp   <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        budget_q   <= cycle_budget;
                        cycles_run <= '0;
                        reg_idx    <= '0;
                        cmp_valid  <= 1'b0;
                        cmp_idx    <= '0;
                        pass       <= 1'b0;
                        halted     <= 1'b0;
                        fail_idx   <= '0;
                        fail_got   <= '0;
                        fail_exp   <= '0;
                    end
                end
                ST_CPURST: begin
                    if (budget_q == '0) reg_idx <= FIRST_IDX;
                end
                ST_RUN: begin
                    if (cycles_run != {CYC_W{1'b1}}) cycles_run <= cycles_run + 1'b1;
                    if (run_exit) begin
                        reg_idx <= FIRST_IDX;
                        halted  <= halt_hit;
                    end
                end
                ST_SCAN: begin
                    cmp_valid <= 1'b1;
                    cmp_idx   <= reg_idx;
                    if (!mismatch && (reg_idx != LAST_IDX)) reg_idx <= reg_idx + 1'b1;
                    if (mismatch) begin
                        fail_idx <= cmp_idx;
                        fail_got <= reg_data;
                        fail_exp <= exp_data;
                    end else if (scan_end) begin
                        pass <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_program_run_checker.sv
// tb/tb_program_run_checker.sv - randomized self-checking bench for program_run_checker
module tb_program_run_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        st;
    logic        sel;
    logic [15:0] bud;
    logic        start0, start1;

    logic        cpurst0, busy0, done0, pass0, halted0;
    logic [4:0]  ridx0, fidx0;
    logic [31:0] pc0, rd0, ed0, fgot0, fexp0;
    logic [15:0] cyc0;

    logic        cpurst1, busy1, done1, pass1, halted1;
    logic [4:0]  ridx1, fidx1;
    logic [31:0] pc1, rd1, ed1, fgot1, fexp1;
    logic [15:0] cyc1;

    logic [31:0] rf [32];
    logic [31:0] ex [32];
    logic [31:0] halt_pc;

    int cyc   = 0;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign start0 = st & ~sel;
    assign start1 = st & sel;

    program_run_checker #(.HALT_MODE(0)) u_dut0 (
        .clk(clk), .reset(reset), .start(start0), .cycle_budget(bud), .cpu_reset(cpurst0),
        .pc(pc0), .reg_idx(ridx0), .reg_data(rd0), .exp_data(ed0), .busy(busy0), .done(done0),
        .pass(pass0), .halted(halted0), .fail_idx(fidx0), .fail_got(fgot0), .fail_exp(fexp0),
        .cycles_run(cyc0)
    );

    program_run_checker #(.HALT_MODE(1), .HALT_STABLE(4)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .cycle_budget(bud), .cpu_reset(cpurst1),
        .pc(pc1), .reg_idx(ridx1), .reg_data(rd1), .exp_data(ed1), .busy(busy1), .done(done1),
        .pass(pass1), .halted(halted1), .fail_idx(fidx1), .fail_got(fgot1), .fail_exp(fexp1),
        .cycles_run(cyc1)
    );

    // Observed outputs of whichever instance is under test
    logic        m_cpurst, m_busy, m_done, m_pass, m_halted;
    logic [4:0]  m_ridx, m_fidx;
    logic [31:0] m_fgot, m_fexp;
    logic [15:0] m_cyc;
    assign m_cpurst = sel ? cpurst1 : cpurst0;
    assign m_busy   = sel ? busy1   : busy0;
    assign m_done   = sel ? done1   : done0;
    assign m_pass   = sel ? pass1   : pass0;
    assign m_halted = sel ? halted1 : halted0;
    assign m_ridx   = sel ? ridx1   : ridx0;
    assign m_fidx   = sel ? fidx1   : fidx0;
    assign m_fgot   = sel ? fgot1   : fgot0;
    assign m_fexp   = sel ? fexp1   : fexp0;
    assign m_cyc    = sel ? cyc1    : cyc0;

    // Cycle counter, synchronous register file / expected ROM reads, and core pc models
    always @(posedge clk) begin
        cyc <= cyc + 1;
        rd0 <= rf[ridx0];
        ed0 <= ex[ridx0];
        rd1 <= rf[ridx1];
        ed1 <= ex[ridx1];
        pc0 <= cpurst0 ? 32'd0 : pc0 + 32'd4;
        pc1 <= cpurst1 ? 32'd0 : ((pc1 == halt_pc) ? pc1 : pc1 + 32'd4);
    end

    function automatic int first_mismatch();
        for (int k = 1; k < 32; k++) if (rf[k] !== ex[k]) return k;
        return 0;
    endfunction

    // RUN cycles until pc has been unchanged for 4 consecutive RUN cycles (pc is 0 before RUN)
    function automatic int halt_cycles(input logic [31:0] h);
        int run = 0;
        logic [31:0] prev = 32'd0;
        logic [31:0] cur;
        for (int i = 0; i < 5000; i++) begin
            cur = (32'(4 * i) >= h) ? h : 32'(4 * i);
            if (cur == prev) run++;
            else run = 0;
            prev = cur;
            if (run == 4) return i + 1;
        end
        return 1 << 30;
    endfunction

    task automatic fill_regs();
        for (int k = 0; k < 32; k++) begin
            rf[k] = $urandom;
            ex[k] = rf[k];
        end
    endtask

    task automatic run_check(input logic which, input int budget, input int pulse_at, input string name);
        int k, eff, hc, exp_done, got_done, lowcnt, busy_err, t0, c;
        logic exp_halted;
        logic [31:0] egot, eexp;
        k = first_mismatch();
        eff = budget;
        exp_halted = 1'b0;
        if (which && budget > 0) begin
            hc = halt_cycles(halt_pc);
            if (hc <= budget) begin
                eff = hc;
                exp_halted = 1'b1;
            end
        end
        exp_done = (k != 0) ? eff + 3 + k : eff + 34;
        egot = (k != 0) ? rf[k] : 32'd0;
        eexp = (k != 0) ? ex[k] : 32'd0;

        @(posedge clk); #1;
        sel = which;
        bud = 16'(budget);
        st  = 1'b1;
        t0  = cyc;
        @(posedge clk); #1;
        st = 1'b0;
        got_done = -1;
        lowcnt = 0;
        busy_err = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            c = cyc - t0;
            if (m_cpurst !== 1'b1) lowcnt++;
            if (m_done === 1'b1) begin
                got_done = c;
                break;
            end
            if (m_busy !== 1'b1) busy_err++;
            st = (c == pulse_at);
        end
        st = 1'b0;

        n_cmp++; if (got_done !== exp_done) begin n_bad++; $display("FAIL %s done_cycle: got %0d expected %0d", name, got_done, exp_done); end
        n_cmp++; if (m_pass !== (k == 0)) begin n_bad++; $display("FAIL %s pass: got %b expected %b", name, m_pass, (k == 0)); end
        n_cmp++; if (m_fidx !== 5'(k)) begin n_bad++; $display("FAIL %s fail_idx: got %0d expected %0d", name, m_fidx, k); end
        n_cmp++; if (m_fgot !== egot) begin n_bad++; $display("FAIL %s fail_got: got %h expected %h", name, m_fgot, egot); end
        n_cmp++; if (m_fexp !== eexp) begin n_bad++; $display("FAIL %s fail_exp: got %h expected %h", name, m_fexp, eexp); end
        n_cmp++; if (m_cyc !== 16'(eff)) begin n_bad++; $display("FAIL %s cycles_run: got %0d expected %0d", name, m_cyc, eff); end
        n_cmp++; if (m_halted !== exp_halted) begin n_bad++; $display("FAIL %s halted: got %b expected %b", name, m_halted, exp_halted); end
        n_cmp++; if (lowcnt != eff) begin n_bad++; $display("FAIL %s cpu_reset_low_cycles: got %0d expected %0d", name, lowcnt, eff); end
        n_cmp++; if (busy_err != 0) begin n_bad++; $display("FAIL %s busy_gaps: got %0d expected 0", name, busy_err); end
    endtask

    task automatic test_reset();
        logic [94:0] v0, v1;
        reset = 1'b0;
        st = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        v0 = {cpurst0, ridx0, busy0, done0, pass0, halted0, fidx0, fgot0, fexp0, cyc0};
        v1 = {cpurst1, ridx1, busy1, done1, pass1, halted1, fidx1, fgot1, fexp1, cyc1};
        n_cmp++; if (v0 !== {1'b1, 94'd0}) begin n_bad++; $display("FAIL reset_dut0: got %h expected %h", v0, {1'b1, 94'd0}); end
        n_cmp++; if (v1 !== {1'b1, 94'd0}) begin n_bad++; $display("FAIL reset_dut1: got %h expected %h", v1, {1'b1, 94'd0}); end
        reset = 1'b1;
    endtask

    task automatic test_fib_pass();
        fill_regs();
        run_check(1'b0, 29, -1, "fib_pass");
    endtask

    task automatic test_r7_corrupt();
        fill_regs();
        ex[7] = 32'hdeadbeef;
        if (rf[7] == 32'hdeadbeef) rf[7] = 32'h0;
        run_check(1'b0, $urandom_range(1, 50), -1, "r7_corrupt");
    endtask

    task automatic test_r1_r31();
        fill_regs();
        ex[1]  = rf[1] ^ 32'h8000_0000;
        ex[31] = rf[31] ^ 32'h1;
        run_check(1'b0, 10, -1, "r1_r31");
    endtask

    task automatic test_last_reg();
        fill_regs();
        ex[31] = rf[31] ^ 32'h0001_0000;
        run_check(1'b0, 3, -1, "r31_only");
    endtask

    task automatic test_budget_zero();
        fill_regs();
        ex[0] = ~rf[0];
        run_check(1'b0, 0, -1, "budget_zero");
        run_check(1'b1, 0, -1, "budget_zero_halt_mode");
    endtask

    task automatic test_halt();
        fill_regs();
        halt_pc = 32'd40;
        run_check(1'b1, 400, 6, "halt_mid_start");
        run_check(1'b1, 15, -1, "halt_budget_tie");
        run_check(1'b1, 14, -1, "budget_before_halt");
    endtask

    task automatic test_random();
        int nbad;
        logic which;
        for (int it = 0; it < 8; it++) begin
            fill_regs();
            nbad = $urandom_range(0, 2);
            for (int j = 0; j < nbad; j++) ex[$urandom_range(0, 31)] ^= (32'd1 << $urandom_range(0, 31));
            which = 1'($urandom_range(0, 1));
            halt_pc = 32'($urandom_range(0, 50) * 4);
            run_check(which, $urandom_range(0, 80), -1, $sformatf("random_%0d", it));
        end
    endtask

    task automatic test_reset_mid_scan();
        logic [94:0] v0;
        bit reached;
        fill_regs();
        ex[20] = rf[20] ^ 32'h0000_0100;
        @(posedge clk); #1;
        sel = 1'b0;
        bud = 16'd3;
        st  = 1'b1;
        @(posedge clk); #1;
        st = 1'b0;
        reached = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ridx0 == 5'd5 && busy0 === 1'b1) begin
                reached = 1;
                break;
            end
        end
        n_cmp++; if (!reached) begin n_bad++; $display("FAIL mid_scan_reach: got 0 expected 1"); end
        reset = 1'b0;
        @(posedge clk); #1;
        v0 = {cpurst0, ridx0, busy0, done0, pass0, halted0, fidx0, fgot0, fexp0, cyc0};
        n_cmp++; if (v0 !== {1'b1, 94'd0}) begin n_bad++; $display("FAIL mid_scan_reset: got %h expected %h", v0, {1'b1, 94'd0}); end
        reset = 1'b1;
        run_check(1'b0, 7, -1, "after_reset");
    endtask

    initial begin
        sel = 1'b0;
        st = 1'b0;
        bud = 16'd0;
        halt_pc = 32'd40;
        reset = 1'b0;
        for (int k = 0; k < 32; k++) begin
            rf[k] = 32'd0;
            ex[k] = 32'd0;
        end
        test_reset();
        test_fib_pass();
        test_r7_corrupt();
        test_r1_r31();
        test_last_reg();
        test_budget_zero();
        test_halt();
        test_random();
        test_reset_mid_scan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
